acq_cmd_sequencer: RTL

//  Parses 8-byte command frames (55 A5 ADDR D3 D2 D1 D0 F0) from the received UDP payload byte stream.

---
 rtl/acq_cmd_sequencer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/acq_cmd_sequencer.sv
// acq_cmd_sequencer
//  Parses 8-byte command frames (55 A5 ADDR D3 D2 D1 D0 F0) from the UDP RX
//  payload stream, holds the acquisition config registers and sequences one
//  ADC capture burst per start command.
// Ports
//  Clk          in   system clock
//  reset        in   synchronous, active-high reset
//  rx_data      in   payload byte, qualified by rx_valid
//  rx_valid     in   one payload byte this cycle
//  rx_last      in   with rx_valid: last payload byte of the packet
//  ch_sel       out  channel select register (bit0 = ad_in1, bit1 = ad_in2)
//  sample_en    out  high for the whole capture window
//  adc_data_en  out  1-cycle strobe: latch one ADC sample
//  tx_en_pulse  out  1-cycle request to UDP TX to send the buffer
//  tx_done      in   UDP TX finished (rising edge used)
//  busy         out  sequencer not idle
//  err_cnt      out  saturating command error counter (only with CMD_ERR_CNT_EN)
// Optional feature macro: CMD_ERR_CNT_EN
module acq_cmd_sequencer #(
   parameter int unsigned CNT_W   = 24,
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned DIV_RST = 49,
   parameter int unsigned CNT_RST = 256
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_last,
   output logic [1:0] ch_sel,
   output logic       sample_en,
   output logic       adc_data_en,
   output logic       tx_en_pulse,
   input  logic       tx_done,
   output logic       busy
`ifdef CMD_ERR_CNT_EN
   ,
   output logic [15:0] err_cnt
`endif
);

   typedef enum logic [2:0] {
      P_H0, P_H1, P_ADDR, P_D3, P_D2, P_D1, P_D0, P_TAIL
   } pstate_t;

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_SAMPLE, S_TX, S_WAIT
   } sstate_t;

   pstate_t           pstate, pstate_n;
   logic [7:0]        faddr, faddr_n;
   logic [31:0]       fdata, fdata_n;
   logic              commit, commit_n;
   logic              perr_c;

   logic [CNT_W-1:0]  cnt_r;
   logic [DIV_W-1:0]  div_r;

   sstate_t           sstate, sstate_n;
   logic [DIV_W-1:0]  div_sh, div_sh_n;
   logic [CNT_W-1:0]  cnt_sh, cnt_sh_n;
   logic [DIV_W-1:0]  gap, gap_n;
   logic [CNT_W-1:0]  scnt, scnt_n;
   logic              sample_en_n, adc_data_en_n, tx_en_pulse_n, busy_n;
   logic              tx_done_q;
   logic [DIV_W-1:0]  gap_c;
   logic [CNT_W-1:0]  scnt_inc_c;
   logic              start_c;
   logic              tx_edge_c;

   assign start_c   = commit && (faddr == 8'h00) && fdata[0];
   assign tx_edge_c = tx_done && !tx_done_q;

   // Frame parser state register; commit is a registered pulse one cycle after the tail byte
   always_ff @(posedge Clk) begin
      if (reset) begin
         pstate <= P_H0;
         faddr  <= '0;
         fdata  <= '0;
         commit <= 1'b0;
      end else begin
         pstate <= pstate_n;
         faddr  <= faddr_n;
         fdata  <= fdata_n;
         commit <= commit_n;
      end
   end

   // Frame parser next state; faddr/fdata stay stable through the commit cycle
   always_comb begin
      pstate_n = pstate;
      faddr_n  = faddr;
      fdata_n  = fdata;
      commit_n = 1'b0;
      perr_c   = 1'b0;
      if (rx_valid) begin
         if (rx_last && (pstate != P_TAIL)) begin
            pstate_n = P_H0;
            perr_c   = 1'b1;
         end else begin
            case (pstate)
               P_H0:    if (rx_data == 8'h55) pstate_n = P_H1;
               P_H1: begin
                  if (rx_data == 8'hA5)      pstate_n = P_ADDR;
                  else if (rx_data == 8'h55) pstate_n = P_H1;
                  else                       pstate_n = P_H0;
               end
               P_ADDR: begin
                  faddr_n  = rx_data;
                  pstate_n = P_D3;
               end
               P_D3: begin
                  fdata_n  = {fdata[23:0], rx_data};
                  pstate_n = P_D2;
               end
               P_D2: begin
                  fdata_n  = {fdata[23:0], rx_data};
                  pstate_n = P_D1;
               end
               P_D1: begin
                  fdata_n  = {fdata[23:0], rx_data};
                  pstate_n = P_D0;
               end
               P_D0: begin
                  fdata_n  = {fdata[23:0], rx_data};
                  pstate_n = P_TAIL;
               end
               P_TAIL: begin
                  pstate_n = P_H0;
                  if (rx_data == 8'hF0) commit_n = 1'b1;
                  else                  perr_c   = 1'b1;
               end
               default: pstate_n = P_H0;
            endcase
         end
      end
   end

   // Config registers; writes land regardless of sequencer state
   always_ff @(posedge Clk) begin
      if (reset) begin
         ch_sel <= 2'b01;
         cnt_r  <= CNT_W'(CNT_RST);
         div_r  <= DIV_W'(DIV_RST);
      end else if (commit) begin
         case (faddr)
            8'h01:   ch_sel <= fdata[1:0];
            8'h02:   cnt_r  <= fdata[CNT_W-1:0];
            8'h03:   div_r  <= fdata[DIV_W-1:0];
            default: ;
         endcase
      end
   end

   // Sequencer state and registered outputs
   always_ff @(posedge Clk) begin
      if (reset) begin
         sstate      <= S_IDLE;
         div_sh      <= '0;
         cnt_sh      <= '0;
         gap         <= '0;
         scnt        <= '0;
         sample_en   <= 1'b0;
         adc_data_en <= 1'b0;
         tx_en_pulse <= 1'b0;
         busy        <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         sstate      <= sstate_n;
         div_sh      <= div_sh_n;
         cnt_sh      <= cnt_sh_n;
         gap         <= gap_n;
         scnt        <= scnt_n;
         sample_en   <= sample_en_n;
         adc_data_en <= adc_data_en_n;
         tx_en_pulse <= tx_en_pulse_n;
         busy        <= busy_n;
         tx_done_q   <= tx_done;
      end
   end

   // Sequencer next state; gap counts idle cycles left before the next strobe
   always_comb begin
      sstate_n      = sstate;
      div_sh_n      = div_sh;
      cnt_sh_n      = cnt_sh;
      gap_n         = gap;
      scnt_n        = scnt;
      sample_en_n   = sample_en;
      adc_data_en_n = 1'b0;
      tx_en_pulse_n = 1'b0;
      gap_c         = adc_data_en ? div_sh : gap;
      scnt_inc_c    = scnt + CNT_W'(1);
      case (sstate)
         S_IDLE: begin
            if (start_c && (cnt_r != '0)) begin
               sstate_n = S_ARM;
               div_sh_n = div_r;
               cnt_sh_n = cnt_r;
            end
         end
         S_ARM: begin
            sstate_n      = S_SAMPLE;
            sample_en_n   = 1'b1;
            adc_data_en_n = 1'b1;
            gap_n         = '0;
            scnt_n        = '0;
         end
         S_SAMPLE: begin
            if (adc_data_en) scnt_n = scnt_inc_c;
            if (adc_data_en && (scnt_inc_c == cnt_sh)) begin
               sstate_n      = S_TX;
               sample_en_n   = 1'b0;
               tx_en_pulse_n = 1'b1;
            end else if (gap_c == '0) begin
               adc_data_en_n = 1'b1;
            end else begin
               gap_n = gap_c - DIV_W'(1);
            end
         end
         S_TX:    sstate_n = S_WAIT;
         S_WAIT:  if (tx_edge_c) sstate_n = S_IDLE;
         default: sstate_n = S_IDLE;
      endcase
      busy_n = (sstate_n != S_IDLE);
   end

`ifdef CMD_ERR_CNT_EN
   logic [1:0]  err_inc_c;
   logic [16:0] err_sum_c;
   logic        unused_c;

   // Frame errors and commit-side errors can coincide in one cycle with back-to-back frames
   assign err_inc_c = 2'(perr_c)
                    + 2'(commit && ((faddr > 8'h03) || (start_c && (sstate != S_IDLE))));
   assign err_sum_c = {1'b0, err_cnt} + 17'(err_inc_c);
   assign unused_c  = ^fdata;

   // Saturating error counter
   always_ff @(posedge Clk) begin
      if (reset)             err_cnt <= '0;
      else if (err_sum_c[16]) err_cnt <= 16'hFFFF;
      else                   err_cnt <= err_sum_c[15:0];
   end
`else
   logic unused_c;
   assign unused_c = ^{fdata, perr_c};
`endif

endmodule
